// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pkg.sv
// gf180mcu_fd_sc_mcu7t5v0__orn_pkg: tree sizing helpers shared by the pipelined OR-reduction macro
package gf180mcu_fd_sc_mcu7t5v0__orn_pkg;
  localparam int MAX_WIDTH = 256;
  function automatic bit fanin_ok(int fanin);
    return fanin >= 2 && fanin <= 4;
  endfunction
  function automatic int node_count(int n, int fanin);
    return fanin < 2 ? n : (n + fanin - 1) / fanin;
  endfunction
  function automatic int tree_depth(int width, int fanin);
    int n = width;
    int l = 0;
    for (int i = 0; i < MAX_WIDTH && (n > 1 || l == 0); i++) begin
      n = node_count(n, fanin);
      l++;
    end
    return l;
  endfunction
  function automatic int level_nodes(int width, int fanin, int k);
    int n = width;
    for (int i = 0; i < k; i++) n = node_count(n, fanin);
    return n;
  endfunction
  function automatic int level_offset(int width, int fanin, int k);
    int o = 0;
    for (int i = 0; i < k; i++) o += level_nodes(width, fanin, i);
    return o;
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pipe_stage.sv
// gf180mcu_fd_sc_mcu7t5v0__orn_pipe_stage: one registered level of FANIN-input OR nodes with valid
module gf180mcu_fd_sc_mcu7t5v0__orn_pipe_stage
  import gf180mcu_fd_sc_mcu7t5v0__orn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int FANIN = 4
) (
  input  logic                                 CLK,
  input  logic                                 RN,
  input  logic [N_IN-1:0]                      in_d,
  input  logic                                 in_v,
  output logic [node_count(N_IN, FANIN)-1:0]   out_d,
  output logic                                 out_v
);
  localparam int N_OUT = node_count(N_IN, FANIN);
  logic [N_OUT*FANIN-1:0] pad;
  logic [N_OUT-1:0]       d_d, d_q;
  logic                   v_d, v_q;
  // zero-pad the last group, OR each group, load only when the incoming level is valid
  always_comb begin
    pad = '0;
    pad[N_IN-1:0] = in_d;
    for (int i = 0; i < N_OUT; i++) d_d[i] = in_v ? |pad[i*FANIN +: FANIN] : d_q[i];
    v_d = in_v;
  end
  // level data and valid registers, cleared by the synchronous reset
  always_ff @(posedge CLK) begin
    if (!RN) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
    end
  end
  assign out_d = d_q;
  assign out_v = v_q;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pipe.sv
// gf180mcu_fd_sc_mcu7t5v0__orn_pipe: pipelined WIDTH-bit OR reduction with valid tracking and sticky result
module gf180mcu_fd_sc_mcu7t5v0__orn_pipe
  import gf180mcu_fd_sc_mcu7t5v0__orn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FANIN = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic             CLR,
  output logic             Z,
  output logic             ZV,
  output logic             ZS,
  inout  wire              VDD,
  inout  wire              VSS
);
  localparam int L   = tree_depth(WIDTH, FANIN);
  localparam int TOT = level_offset(WIDTH, FANIN, L + 1);
  localparam int OF  = level_offset(WIDTH, FANIN, L - 1);
  localparam int NF  = level_nodes(WIDTH, FANIN, L - 1);
  logic [TOT-1:0] lvl_d;
  logic [L:0]     lvl_v;
  logic           zs_d, zs_q;
  wire unused_supply = &{1'b0, VDD, VSS};
  if (WIDTH < 2 || WIDTH > MAX_WIDTH || !fanin_ok(FANIN)) begin : g_bad
    $error("orn_pipe: illegal WIDTH=%0d or FANIN=%0d", WIDTH, FANIN);
  end
  assign lvl_d[WIDTH-1:0] = A;
  assign lvl_v[0] = EN;
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int OI = level_offset(WIDTH, FANIN, k - 1);
    localparam int NI = level_nodes(WIDTH, FANIN, k - 1);
    localparam int OO = level_offset(WIDTH, FANIN, k);
    localparam int NO = level_nodes(WIDTH, FANIN, k);
    gf180mcu_fd_sc_mcu7t5v0__orn_pipe_stage #(.N_IN(NI), .FANIN(FANIN)) u_stage (
      .CLK   (CLK),
      .RN    (RN),
      .in_d  (lvl_d[OI +: NI]),
      .in_v  (lvl_v[k-1]),
      .out_d (lvl_d[OO +: NO]),
      .out_v (lvl_v[k])
    );
  end
  // sticky result: a delivered 1 wins over a same-cycle clear
  always_comb zs_d = (CLR ? 1'b0 : zs_q) | (lvl_v[L-1] & |lvl_d[OF +: NF]);
  // sticky flop
  always_ff @(posedge CLK) zs_q <= !RN ? 1'b0 : zs_d;
  assign Z  = lvl_d[TOT-1];
  assign ZV = lvl_v[L];
  assign ZS = zs_q;
  specify
    (CLK => Z) = (1.0, 1.0);
    (CLK => ZV) = (1.0, 1.0);
    (CLK => ZS) = (1.0, 1.0);
    $setup(A, posedge CLK, 0.1);
    $hold(posedge CLK, A, 0.1);
    $setup(EN, posedge CLK, 0.1);
    $hold(posedge CLK, EN, 0.1);
    $setup(CLR, posedge CLK, 0.1);
    $hold(posedge CLK, CLR, 0.1);
    $setup(RN, posedge CLK, 0.1);
    $hold(posedge CLK, RN, 0.1);
  endspecify
endmodule
